branch_predictor: RTL and testbench

Parametrised successor to the separate BHT and BTB blocks: one unit with a gshare-indexed 2-bit pattern table, a tagged BTB that records branch type, and a return address stack (RAS). The fetch stage looks it up combinationally on lookup_PC. The execute stage resolves each branch and sends updates or mispredict repairs. Speculative global history and the RAS pointer are checkpointed per lookup and travel down the pipe, so they can be restored exactly on a mispredict.

---
 rtl/branch_predictor_if.sv | 36 +++
 rtl/branch_predictor.sv | 157 +++++++++++++++
 tb/tb_branch_predictor.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and execute-side resolve/repair signals of the branch predictor.
// The master is the pipeline; the slave is the predictor.
interface branch_predictor_if #(
    parameter int GHR_W = 6,
    parameter int PTR   = 2
);
    logic [31:0]      lookup_PC;
    logic             fetch_advance;
    logic             predict_taken;
    logic             BTB_hit;
    logic [31:0]      BTB_PC;
    logic [GHR_W-1:0] lookup_ghr;
    logic [PTR-1:0]   lookup_ras_ptr;
    logic             upd_en;
    logic [31:0]      upd_PC;
    logic [1:0]       upd_type;
    logic             upd_taken;
    logic [31:0]      upd_target;
    logic [GHR_W-1:0] upd_ghr;
    logic [PTR-1:0]   upd_ras_ptr;
    logic             upd_mispredict;

    modport master (
        output lookup_PC, fetch_advance,
        output upd_en, upd_PC, upd_type, upd_taken, upd_target,
        output upd_ghr, upd_ras_ptr, upd_mispredict,
        input  predict_taken, BTB_hit, BTB_PC, lookup_ghr, lookup_ras_ptr
    );

    modport slave (
        input  lookup_PC, fetch_advance,
        input  upd_en, upd_PC, upd_type, upd_taken, upd_target,
        input  upd_ghr, upd_ras_ptr, upd_mispredict,
        output predict_taken, BTB_hit, BTB_PC, lookup_ghr, lookup_ras_ptr
    );
endinterface

// File: rtl/branch_predictor.sv
// Gshare 2-bit pattern table, tagged direct-mapped BTB with branch type, and a return address
// stack. Speculative GHR / RAS pointer are exported per lookup and restored on mispredict.
module branch_predictor #(
    parameter int ENTRIES   = 64,
    parameter int GHR_BITS  = 6,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    branch_predictor_if.slave bp
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int GHR_W = (GHR_BITS > 0) ? GHR_BITS : 1;
    localparam int PTR   = $clog2(RAS_DEPTH);
    localparam int TAG_W = 30 - IDX;

    localparam logic [1:0] T_COND = 2'b00;
    localparam logic [1:0] T_CALL = 2'b10;
    localparam logic [1:0] T_RET  = 2'b11;
    localparam logic [PTR:0] RAS_FULL = (PTR+1)'(RAS_DEPTH);

    logic [1:0]       r_pht   [ENTRIES];
    logic             r_valid [ENTRIES];
    logic [TAG_W-1:0] r_tag   [ENTRIES];
    logic [31:0]      r_tgt   [ENTRIES];
    logic [1:0]       r_type  [ENTRIES];
    logic [31:0]      r_ras   [RAS_DEPTH];
    logic [GHR_W-1:0] r_ghr;
    logic [PTR-1:0]   r_ras_ptr;
    logic [PTR:0]     r_ras_cnt;

    logic [IDX-1:0]   w_ghr_ext;
    logic [IDX-1:0]   w_upd_ghr_ext;
    logic [IDX-1:0]   w_idx;
    logic [IDX-1:0]   w_uidx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic [1:0]       w_type;
    logic             w_ras_empty;
    logic [PTR-1:0]   w_ras_top;
    logic [PTR:0]     w_cnt_inc;
    logic             w_repair;
    logic             w_spec;
    logic [GHR_W:0]   w_ghr_spec_sh;
    logic [GHR_W:0]   w_ghr_upd_sh;

    // With GHR_BITS=0 r_ghr is held at zero, which degenerates the index to plain bimodal.
    assign w_ghr_ext     = IDX'(r_ghr);
    assign w_upd_ghr_ext = (GHR_BITS > 0) ? IDX'(bp.upd_ghr) : '0;

    assign w_idx       = bp.lookup_PC[IDX+1:2] ^ w_ghr_ext;
    assign w_uidx      = bp.upd_PC[IDX+1:2] ^ w_upd_ghr_ext;
    assign w_tag       = bp.lookup_PC[31:IDX+2];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_type      = r_type[w_idx];
    assign w_ras_empty = (r_ras_cnt == '0);
    assign w_ras_top   = r_ras_ptr - PTR'(1);
    assign w_cnt_inc   = (r_ras_cnt == RAS_FULL) ? r_ras_cnt : r_ras_cnt + (PTR+1)'(1);

    assign w_repair      = bp.upd_en && bp.upd_mispredict;
    assign w_spec        = bp.fetch_advance && !w_repair && w_hit;
    assign w_ghr_spec_sh = {r_ghr, r_pht[w_idx][1]};
    assign w_ghr_upd_sh  = {bp.upd_ghr, bp.upd_taken};

    assign bp.BTB_hit        = w_hit;
    assign bp.lookup_ghr     = r_ghr;
    assign bp.lookup_ras_ptr = r_ras_ptr;

    always_comb begin
        bp.predict_taken = 1'b0;
        bp.BTB_PC        = '0;
        if (w_hit) begin
            case (w_type)
                T_COND: begin
                    bp.predict_taken = r_pht[w_idx][1];
                    bp.BTB_PC        = r_tgt[w_idx];
                end
                T_RET: begin
                    bp.predict_taken = 1'b1;
                    bp.BTB_PC        = w_ras_empty ? r_tgt[w_idx] : r_ras[w_ras_top];
                end
                default: begin
                    bp.predict_taken = 1'b1;
                    bp.BTB_PC        = r_tgt[w_idx];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_pht[i]   <= 2'b01;
                r_valid[i] <= 1'b0;
            end
            r_ghr     <= '0;
            r_ras_ptr <= '0;
            r_ras_cnt <= '0;
        end else begin
            if (bp.upd_en && bp.upd_type == T_COND) begin
                if (bp.upd_taken && r_pht[w_uidx] != 2'b11)
                    r_pht[w_uidx] <= r_pht[w_uidx] + 2'b01;
                else if (!bp.upd_taken && r_pht[w_uidx] != 2'b00)
                    r_pht[w_uidx] <= r_pht[w_uidx] - 2'b01;
            end

            // Not-taken conditionals never allocate, so a cold branch stays out of the BTB.
            if (bp.upd_en && (bp.upd_taken || bp.upd_type != T_COND)) begin
                r_valid[w_uidx] <= 1'b1;
                r_tag[w_uidx]   <= bp.upd_PC[31:IDX+2];
                r_tgt[w_uidx]   <= bp.upd_target;
                r_type[w_uidx]  <= bp.upd_type;
            end

            if (w_repair) begin
                if (GHR_BITS > 0)
                    r_ghr <= (bp.upd_type == T_COND) ? w_ghr_upd_sh[GHR_W-1:0] : bp.upd_ghr;
                // Restore the checkpointed pointer, then replay the resolved instruction's own stack op.
                case (bp.upd_type)
                    T_CALL: begin
                        r_ras[bp.upd_ras_ptr] <= bp.upd_PC + 32'd4;
                        r_ras_ptr             <= bp.upd_ras_ptr + PTR'(1);
                        r_ras_cnt             <= w_cnt_inc;
                    end
                    T_RET: begin
                        if (!w_ras_empty) begin
                            r_ras_ptr <= bp.upd_ras_ptr - PTR'(1);
                            r_ras_cnt <= r_ras_cnt - (PTR+1)'(1);
                        end else begin
                            r_ras_ptr <= bp.upd_ras_ptr;
                        end
                    end
                    default: r_ras_ptr <= bp.upd_ras_ptr;
                endcase
            end else if (w_spec) begin
                case (w_type)
                    T_COND: begin
                        if (GHR_BITS > 0)
                            r_ghr <= w_ghr_spec_sh[GHR_W-1:0];
                    end
                    T_CALL: begin
                        r_ras[r_ras_ptr] <= bp.lookup_PC + 32'd4;
                        r_ras_ptr        <= r_ras_ptr + PTR'(1);
                        r_ras_cnt        <= w_cnt_inc;
                    end
                    T_RET: begin
                        if (!w_ras_empty) begin
                            r_ras_ptr <= w_ras_top;
                            r_ras_cnt <= r_ras_cnt - (PTR+1)'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboarded bench for branch_predictor: directed scenarios plus randomized traffic, each cycle's
// expected lookup response is queued by the driver and compared by a negedge monitor.
module tb_branch_predictor;
    localparam int ENTRIES   = 256;
    localparam int GHR_BITS  = 6;
    localparam int RAS_DEPTH = 4;
    localparam int IDX       = 8;
    localparam int PTR       = 2;
    localparam int M         = ENTRIES - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_if #(.GHR_W(GHR_BITS), .PTR(PTR)) bp ();

    branch_predictor #(.ENTRIES(ENTRIES), .GHR_BITS(GHR_BITS), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp)
    );

    typedef struct {
        logic [31:0] lpc;
        logic        hit;
        logic        taken;
        logic [31:0] pc;
        logic [5:0]  ghr;
        logic [1:0]  ptr;
        bit          has_c;
        string       nm;
        logic        c_hit;
        logic        c_taken;
        logic [31:0] c_pc;
        bit          c_chk_g;
        logic [5:0]  c_ghr;
    } exp_t;

    exp_t sb_q[$];
    exp_t me;
    bit   lk_valid = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: plain arrays and integer arithmetic.
    int          m_pht [ENTRIES];
    bit          m_v   [ENTRIES];
    int unsigned m_tag [ENTRIES];
    int unsigned m_tgt [ENTRIES];
    int          m_type[ENTRIES];
    int unsigned m_ras [RAS_DEPTH];
    int          m_ghr, m_ptr, m_cnt;

    bit          pend_c = 1'b0;
    string       pend_nm;
    logic        pend_hit, pend_taken;
    logic [31:0] pend_pc;
    bit          pend_chk_g;
    logic [5:0]  pend_ghr;

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_pht[i] = 1;
            m_v[i]   = 1'b0;
        end
        m_ghr = 0; m_ptr = 0; m_cnt = 0;
    endtask

    task automatic expc(input string nm, input bit h, input bit tk, input logic [31:0] pc,
                        input bit chk_g, input logic [5:0] g);
        pend_c = 1'b1; pend_nm = nm; pend_hit = h; pend_taken = tk; pend_pc = pc;
        pend_chk_g = chk_g; pend_ghr = g;
    endtask

    task automatic drive(input bit rst_v, input logic [31:0] lpc, input bit adv,
                         input bit ue, input logic [31:0] upc, input logic [1:0] ut, input bit utk,
                         input logic [31:0] utgt, input logic [5:0] ughr, input logic [1:0] urp,
                         input bit umis);
        exp_t e;
        int   li, ui, t, pht_pre;
        bit   hit;
        rst = rst_v;
        bp.lookup_PC = lpc; bp.fetch_advance = adv;
        bp.upd_en = ue; bp.upd_PC = upc; bp.upd_type = ut; bp.upd_taken = utk;
        bp.upd_target = utgt; bp.upd_ghr = ughr; bp.upd_ras_ptr = urp; bp.upd_mispredict = umis;

        li      = int'((lpc >> 2) & M) ^ m_ghr;
        hit     = m_v[li] && (m_tag[li] == (lpc >> (IDX + 2)));
        t       = m_type[li];
        pht_pre = m_pht[li];
        e.lpc   = lpc;
        e.hit   = hit;
        e.taken = hit && (t != 0 || pht_pre >= 2);
        if (!hit)                  e.pc = 32'h0;
        else if (t == 3 && m_cnt > 0) e.pc = m_ras[(m_ptr + RAS_DEPTH - 1) % RAS_DEPTH];
        else                       e.pc = m_tgt[li];
        e.ghr = 6'(m_ghr);
        e.ptr = 2'(m_ptr);
        e.has_c = pend_c; e.nm = pend_nm; e.c_hit = pend_hit; e.c_taken = pend_taken;
        e.c_pc = pend_pc; e.c_chk_g = pend_chk_g; e.c_ghr = pend_ghr;
        pend_c = 1'b0;
        sb_q.push_back(e);
        lk_valid = 1'b1;

        if (!rst_v) begin
            model_reset();
        end else begin
            if (ue) begin
                ui = int'((upc >> 2) & M) ^ int'(ughr);
                if (ut == 2'b00) begin
                    if (utk) m_pht[ui] = (m_pht[ui] == 3) ? 3 : m_pht[ui] + 1;
                    else     m_pht[ui] = (m_pht[ui] == 0) ? 0 : m_pht[ui] - 1;
                end
                if (utk || ut != 2'b00) begin
                    m_v[ui] = 1'b1; m_tag[ui] = upc >> (IDX + 2); m_tgt[ui] = utgt; m_type[ui] = int'(ut);
                end
            end
            if (ue && umis) begin
                m_ghr = (ut == 2'b00) ? (((int'(ughr) << 1) | int'(utk)) & 63) : int'(ughr);
                m_ptr = int'(urp);
                if (ut == 2'b10) begin
                    m_ras[urp] = upc + 4;
                    m_ptr = (int'(urp) + 1) % RAS_DEPTH;
                    if (m_cnt < RAS_DEPTH) m_cnt++;
                end else if (ut == 2'b11 && m_cnt > 0) begin
                    m_ptr = (int'(urp) + RAS_DEPTH - 1) % RAS_DEPTH;
                    m_cnt--;
                end
            end else if (adv && hit) begin
                if (t == 0) begin
                    m_ghr = ((m_ghr << 1) | (pht_pre >> 1)) & 63;
                end else if (t == 2) begin
                    m_ras[m_ptr] = lpc + 4;
                    m_ptr = (m_ptr + 1) % RAS_DEPTH;
                    if (m_cnt < RAS_DEPTH) m_cnt++;
                end else if (t == 3 && m_cnt > 0) begin
                    m_ptr = (m_ptr + RAS_DEPTH - 1) % RAS_DEPTH;
                    m_cnt--;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [31:0] lpc, input bit adv);
        drive(1'b1, lpc, adv, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 6'h0, 2'd0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] upc, input logic [1:0] ut, input bit utk,
                       input logic [31:0] utgt, input logic [5:0] ughr);
        drive(1'b1, 32'h0, 1'b0, 1'b1, upc, ut, utk, utgt, ughr, 2'd0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (lk_valid) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_underflow: monitor found no expected entry");
            end else begin
                me = sb_q.pop_front();
                if (bp.BTB_hit === me.hit && bp.predict_taken === me.taken && bp.BTB_PC === me.pc &&
                    bp.lookup_ghr === me.ghr && bp.lookup_ras_ptr === me.ptr)
                    n_pass++;
                else
                    $display("FAIL model_lookup pc=%h got hit=%b tk=%b tgt=%h ghr=%h ptr=%0d want hit=%b tk=%b tgt=%h ghr=%h ptr=%0d",
                             me.lpc, bp.BTB_hit, bp.predict_taken, bp.BTB_PC, bp.lookup_ghr, bp.lookup_ras_ptr,
                             me.hit, me.taken, me.pc, me.ghr, me.ptr);
                if (me.has_c) begin
                    n_checks++;
                    if (bp.BTB_hit === me.c_hit && bp.predict_taken === me.c_taken && bp.BTB_PC === me.c_pc &&
                        (!me.c_chk_g || bp.lookup_ghr === me.c_ghr))
                        n_pass++;
                    else
                        $display("FAIL %s pc=%h got hit=%b tk=%b tgt=%h ghr=%h want hit=%b tk=%b tgt=%h ghr=%h",
                                 me.nm, me.lpc, bp.BTB_hit, bp.predict_taken, bp.BTB_PC, bp.lookup_ghr,
                                 me.c_hit, me.c_taken, me.c_pc, me.c_ghr);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [31:0] pool [20];
    logic [31:0] lpc_r, upc_r, tgt_r;
    int          wait_cyc;

    initial begin
        bp.lookup_PC = '0; bp.fetch_advance = 1'b0; bp.upd_en = 1'b0; bp.upd_PC = '0;
        bp.upd_type = '0; bp.upd_taken = 1'b0; bp.upd_target = '0; bp.upd_ghr = '0;
        bp.upd_ras_ptr = '0; bp.upd_mispredict = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        expc("reset_lookup", 1'b0, 1'b0, 32'h0, 1'b1, 6'h0);     look(32'h100, 1'b0);

        upd(32'h200, 2'b00, 1'b1, 32'h180, 6'h0);
        upd(32'h200, 2'b00, 1'b1, 32'h180, 6'h0);
        expc("cond_two_taken", 1'b1, 1'b1, 32'h180, 1'b0, 6'h0); look(32'h200, 1'b0);
        upd(32'h200, 2'b00, 1'b1, 32'h180, 6'h0);
        repeat (3) upd(32'h200, 2'b00, 1'b0, 32'h0, 6'h0);
        expc("cond_nt_valid", 1'b1, 1'b0, 32'h180, 1'b0, 6'h0);  look(32'h200, 1'b0);

        upd(32'h200, 2'b00, 1'b1, 32'h180, 6'h0);
        expc("same_cycle_old", 1'b1, 1'b0, 32'h180, 1'b0, 6'h0);
        drive(1'b1, 32'h200, 1'b0, 1'b1, 32'h200, 2'b00, 1'b1, 32'h180, 6'h0, 2'd0, 1'b0);
        expc("same_cycle_new", 1'b1, 1'b1, 32'h180, 1'b0, 6'h0); look(32'h200, 1'b0);

        upd(32'h1000, 2'b01, 1'b1, 32'h2000, 6'h0);
        expc("alias_own", 1'b1, 1'b1, 32'h2000, 1'b0, 6'h0);      look(32'h1000, 1'b0);
        expc("alias_miss", 1'b0, 1'b0, 32'h0, 1'b0, 6'h0);        look(32'h1000 + 4 * ENTRIES, 1'b0);

        upd(32'h300, 2'b10, 1'b1, 32'h500, 6'h0);
        upd(32'h400, 2'b11, 1'b1, 32'h600, 6'h0);
        expc("call_fetch", 1'b1, 1'b1, 32'h500, 1'b0, 6'h0);      look(32'h300, 1'b1);
        expc("ret_top", 1'b1, 1'b1, 32'h304, 1'b0, 6'h0);         look(32'h400, 1'b1);

        for (int k = 1; k < 5; k++) upd(32'h300 + 32'(k * 16), 2'b10, 1'b1, 32'h500, 6'h0);
        for (int k = 0; k < 5; k++) look(32'h300 + 32'(k * 16), 1'b1);
        expc("ret_nest5", 1'b1, 1'b1, 32'h344, 1'b0, 6'h0);       look(32'h400, 1'b1);
        expc("ret_nest4", 1'b1, 1'b1, 32'h334, 1'b0, 6'h0);       look(32'h400, 1'b1);
        expc("ret_nest3", 1'b1, 1'b1, 32'h324, 1'b0, 6'h0);       look(32'h400, 1'b1);
        expc("ret_nest2", 1'b1, 1'b1, 32'h314, 1'b0, 6'h0);       look(32'h400, 1'b1);
        expc("ret_empty_fallback", 1'b1, 1'b1, 32'h600, 1'b0, 6'h0); look(32'h400, 1'b1);

        upd(32'h200, 2'b00, 1'b1, 32'h180, 6'h01);
        upd(32'h200, 2'b00, 1'b1, 32'h180, 6'h01);
        expc("ghr_first", 1'b1, 1'b1, 32'h180, 1'b1, 6'h00);      look(32'h200, 1'b1);
        expc("ghr_second", 1'b1, 1'b1, 32'h180, 1'b1, 6'h01);     look(32'h200, 1'b1);
        expc("ghr_pre_repair", 1'b1, 1'b1, 32'h180, 1'b1, 6'h03);
        drive(1'b1, 32'h20C, 1'b1, 1'b1, 32'h200, 2'b00, 1'b0, 32'h180, 6'b000011, 2'd1, 1'b1);
        expc("ghr_repair", 1'b0, 1'b0, 32'h0, 1'b1, 6'b000110);   look(32'h100, 1'b0);

        drive(1'b0, 32'h200, 1'b0, 1'b1, 32'h200, 2'b00, 1'b1, 32'h180, 6'h0, 2'd0, 1'b0);
        expc("post_reset_cond", 1'b0, 1'b0, 32'h0, 1'b1, 6'h0);   look(32'h200, 1'b0);
        expc("post_reset_jal", 1'b0, 1'b0, 32'h0, 1'b1, 6'h0);    look(32'h1000, 1'b0);

        for (int k = 0; k < 16; k++) pool[k] = 32'h2000 + 32'(k * 4);
        for (int k = 16; k < 20; k++) pool[k] = 32'h2000 + 32'((k - 15) * 4 * ENTRIES);
        for (int n = 0; n < 3000; n++) begin
            lpc_r = pool[$urandom_range(0, 19)];
            upc_r = pool[$urandom_range(0, 19)];
            tgt_r = $urandom & 32'hFFFF_FFFC;
            drive(($urandom_range(0, 199) != 0), lpc_r, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), upc_r, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  tgt_r, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0));
        end

        wait_cyc = 0;
        while (sb_q.size() != 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        lk_valid = 1'b0;
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
